// File: rtl/quant_scheduler.sv
// quant_scheduler: round-robin issue of 8x8 blocks from NUM_REQ DCT engines to one shared quantizer, gated by downstream credits.
// Handshake at edge t drives q_enable/q_z in cycle t+1; define QSCHED_STRICT_ORDER_EN for fixed 0..NUM_REQ-1 grant order.
module quant_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int CREDITS = 2,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0][7:0][7:0][10:0]    req_block,
  output logic                                  q_enable,
  output logic [7:0][7:0][10:0]                 q_z,
  input  logic                                  q_out_enable,
  output logic                                  out_valid,
  output logic [SRC_W-1:0]                      out_src,
  input  logic                                  credit_ret,
  output logic [3:0]                            in_flight,
  output logic                                  err
);

  localparam int TAG_DEPTH = 8;

  logic [3:0]       credits;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_any;
  logic             issue;
  logic             pop;
  logic             credit_full;
  logic [SRC_W-1:0] tag_mem [TAG_DEPTH];
  logic [2:0]       wr_ptr;
  logic [2:0]       rd_ptr;

`ifdef QSCHED_STRICT_ORDER_EN
  logic [SRC_W-1:0] next_idx;

  always_comb begin
    grant_idx = next_idx;
    grant_any = req_valid[next_idx];
  end
`else
  logic [SRC_W-1:0] last_grant;
  int               cand;

  // First valid requester after last_grant, wrapping modulo NUM_REQ.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_any && req_valid[SRC_W'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = SRC_W'(cand);
      end
    end
  end
`endif

  assign issue       = grant_any && (credits != 4'd0) && !rst;
  assign credit_full = (credits == 4'(CREDITS));
  assign pop         = q_out_enable && (in_flight != 4'd0);
  assign out_valid   = q_out_enable;
  assign out_src     = tag_mem[rd_ptr];

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_enable  <= 1'b0;
      q_z       <= '0;
      credits   <= 4'(CREDITS);
      in_flight <= 4'd0;
      err       <= 1'b0;
      wr_ptr    <= 3'd0;
      rd_ptr    <= 3'd0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem[i] <= '0;
`ifdef QSCHED_STRICT_ORDER_EN
      next_idx  <= '0;
`else
      last_grant <= SRC_W'(NUM_REQ - 1);
`endif
    end else begin
      q_enable <= issue;
      if (issue) begin
        q_z             <= req_block[grant_idx];
        tag_mem[wr_ptr] <= grant_idx;
        wr_ptr          <= wr_ptr + 3'd1;
`ifdef QSCHED_STRICT_ORDER_EN
        next_idx <= (next_idx == SRC_W'(NUM_REQ - 1)) ? '0 : next_idx + 1'b1;
`else
        last_grant <= grant_idx;
`endif
      end
      if (pop) rd_ptr <= rd_ptr + 3'd1;

      case ({issue, pop})
        2'b10:   in_flight <= in_flight + 4'd1;
        2'b01:   in_flight <= in_flight - 4'd1;
        default: in_flight <= in_flight;
      endcase

      // A return while already full saturates; the error is reported instead.
      if (issue && !credit_ret)
        credits <= credits - 4'd1;
      else if (credit_ret && !issue && !credit_full)
        credits <= credits + 4'd1;

      if ((credit_ret && !issue && credit_full) ||
          (q_out_enable && (in_flight == 4'd0)) ||
          (issue && !pop && (in_flight == 4'(TAG_DEPTH))))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_quant_scheduler.sv
// Self-checking bench for quant_scheduler with a queue-based reference model and a 4-cycle quantizer stand-in.
module tb_quant_scheduler;
  localparam int N  = 3;
  localparam int CR = 3;
  localparam int SW = 2;
  typedef logic [7:0][7:0][10:0] blk_t;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [N-1:0]               req_valid;
  logic [N-1:0]               req_ready;
  logic [N-1:0][7:0][7:0][10:0] req_block;
  logic                       q_enable;
  blk_t                       q_z;
  logic                       q_out_enable;
  logic                       out_valid;
  logic [SW-1:0]              out_src;
  logic                       credit_ret;
  logic [3:0]                 in_flight;
  logic                       err;

  always #5 clk = ~clk;

  quant_scheduler #(.NUM_REQ(N), .CREDITS(CR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_block(req_block), .q_enable(q_enable), .q_z(q_z),
    .q_out_enable(q_out_enable), .out_valid(out_valid), .out_src(out_src),
    .credit_ret(credit_ret), .in_flight(in_flight), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model
  int   m_credits;
`ifdef QSCHED_STRICT_ORDER_EN
  int   m_ptr;
`else
  int   m_last;
`endif
  int   m_tags[$];
  bit   m_err;
  bit   m_qen;
  blk_t m_qz;
  logic [3:0] qpipe;
  bit   spur;

  // per-cycle snapshot and expectations
  logic [N-1:0] obs_ready, exp_ready;
  logic         obs_qen, obs_outv, obs_err, exp_qen, exp_err;
  blk_t         obs_qz, exp_qz;
  logic [SW-1:0] obs_src;
  logic [3:0]   obs_infl;
  int           exp_infl, exp_src, g_this;
  bit           exp_has_src;

  function automatic blk_t rand_blk();
    blk_t b;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        b[i][j] = 11'($urandom);
    return b;
  endfunction

  function automatic int pick(logic [N-1:0] v);
`ifdef QSCHED_STRICT_ORDER_EN
    return v[m_ptr] ? m_ptr : -1;
`else
    for (int i = 0; i < N; i++) if (v[i] && i > m_last) return i;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
`endif
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    q_out_enable = qpipe[3] | spur;
    @(negedge clk);
    obs_ready = req_ready; obs_qen = q_enable; obs_qz = q_z; obs_src = out_src;
    obs_outv = out_valid; obs_infl = in_flight; obs_err = err;
    g_this = (rst || m_credits == 0) ? -1 : pick(req_valid);
    exp_ready = '0;
    if (g_this >= 0) exp_ready[g_this] = 1'b1;
    exp_qen = m_qen; exp_qz = m_qz; exp_err = m_err; exp_infl = m_tags.size();
    exp_has_src = (m_tags.size() > 0);
    exp_src = exp_has_src ? m_tags[0] : 0;
    @(posedge clk);
    if (rst) begin
      m_credits = CR;
`ifdef QSCHED_STRICT_ORDER_EN
      m_ptr = 0;
`else
      m_last = N - 1;
`endif
      m_tags.delete(); m_err = 0; m_qen = 0; m_qz = '0; qpipe = '0;
    end else begin
      qpipe = {qpipe[2:0], obs_qen};
      m_qen = (g_this >= 0);
      if (g_this >= 0) m_qz = req_block[g_this];
      if (q_out_enable) begin
        if (m_tags.size() > 0) void'(m_tags.pop_front());
        else m_err = 1;
      end
      if (g_this >= 0) m_tags.push_back(g_this);
      if (g_this >= 0 && !credit_ret) m_credits--;
      else if (credit_ret && g_this < 0) begin
        if (m_credits == CR) m_err = 1;
        else m_credits++;
      end
      if (g_this >= 0) begin
`ifdef QSCHED_STRICT_ORDER_EN
        m_ptr = (m_ptr + 1) % N;
`else
        m_last = g_this;
`endif
      end
    end
    #1;
    if (!rst && g_this >= 0) req_block[g_this] = rand_blk();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; credit_ret = 1'b0; spur = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; credit_ret = 1'b0; spur = 1'b0;
    tick();
    n_checks++;
    if (obs_ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", obs_ready); else n_pass++;
    tick();
    n_checks++;
    if (obs_qen !== 1'b0) $display("FAIL reset_qen: got %b want 0", obs_qen); else n_pass++;
    n_checks++;
    if (obs_qz !== '0) $display("FAIL reset_qz: got %h want 0", obs_qz); else n_pass++;
    n_checks++;
    if (obs_src !== 2'd0) $display("FAIL reset_src: got %0d want 0", obs_src); else n_pass++;
    n_checks++;
    if (obs_infl !== 4'd0) $display("FAIL reset_inflight: got %0d want 0", obs_infl); else n_pass++;
    n_checks++;
    if (obs_err !== 1'b0) $display("FAIL reset_err: got %b want 0", obs_err); else n_pass++;
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_single();
    blk_t sent;
    int   first;
    logic [SW-1:0] src_at;
    logic [N-1:0] want;
    do_reset();
    req_valid = 3'b001;
    sent = req_block[0];
    tick();
    n_checks++;
    if (obs_ready !== 3'b001) $display("FAIL single_grant: got %b want 001", obs_ready); else n_pass++;
    req_valid = '0;
    first = -1; src_at = '0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 1) begin
        n_checks++;
        if (obs_qen !== 1'b1) $display("FAIL single_qen: got %b want 1", obs_qen); else n_pass++;
        n_checks++;
        if (obs_qz !== sent) $display("FAIL single_qz: got %h want %h", obs_qz, sent); else n_pass++;
        n_checks++;
        if (obs_infl !== 4'd1) $display("FAIL single_inflight: got %0d want 1", obs_infl); else n_pass++;
      end
      if (obs_outv && first < 0) begin first = i; src_at = obs_src; end
    end
    n_checks++;
    if (first != 5) $display("FAIL single_latency: got %0d want 5", first); else n_pass++;
    n_checks++;
    if (src_at !== 2'd0) $display("FAIL single_src: got %0d want 0", src_at); else n_pass++;
    // wrap-around: requester 0 absent, so 1 wins after reset
    do_reset();
    req_valid = 3'b110;
`ifdef QSCHED_STRICT_ORDER_EN
    want = 3'b000;
`else
    want = 3'b010;
`endif
    tick();
    n_checks++;
    if (obs_ready !== want) $display("FAIL wrap_grant: got %b want %b", obs_ready, want); else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    int gi;
    do_reset();
    req_valid = '1;
    for (int k = 0; k < 14; k++) begin
      credit_ret = (CR - m_credits) > 0;
      tick();
      gi = onehot_idx(obs_ready);
      n_checks++;
      if (gi != k % N) $display("FAIL b2b_grant[%0d]: got %0d want %0d", k, gi, k % N); else n_pass++;
      if (k >= 1) begin
        n_checks++;
        if (obs_qen !== 1'b1) $display("FAIL b2b_qen[%0d]: got %b want 1", k, obs_qen); else n_pass++;
      end
      if (k >= 5) begin
        n_checks++;
        if (obs_outv !== 1'b1 || int'(obs_src) != (k - 5) % N)
          $display("FAIL b2b_out[%0d]: got v=%b src=%0d want v=1 src=%0d", k, obs_outv, obs_src, (k - 5) % N);
        else n_pass++;
      end
    end
    req_valid = '0; credit_ret = 1'b0;
  endtask

  task automatic test_credit_limit();
    int cnt;
    do_reset();
    req_valid = '1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_ready != '0) cnt++;
    end
    n_checks++;
    if (cnt != CR) $display("FAIL credit_issues: got %0d want %0d", cnt, CR); else n_pass++;
    n_checks++;
    if (obs_ready !== 3'b000) $display("FAIL credit_stall: got %b want 000", obs_ready); else n_pass++;
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obs_ready != '0) cnt++;
    end
    n_checks++;
    if (cnt != 1) $display("FAIL credit_one_more: got %0d want 1", cnt); else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_err();
    int cnt;
    do_reset();
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    tick();
    n_checks++;
    if (obs_err !== 1'b1) $display("FAIL err_credit: got %b want 1", obs_err); else n_pass++;
    tick(); tick(); tick();
    n_checks++;
    if (obs_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", obs_err); else n_pass++;
    req_valid = '1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_ready != '0) cnt++;
    end
    n_checks++;
    if (cnt != CR) $display("FAIL err_saturate: got %0d issues want %0d", cnt, CR); else n_pass++;
    do_reset();
    tick();
    n_checks++;
    if (obs_err !== 1'b0) $display("FAIL err_cleared: got %b want 0", obs_err); else n_pass++;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    n_checks++;
    if (obs_err !== 1'b1) $display("FAIL err_spurious: got %b want 1", obs_err); else n_pass++;
    n_checks++;
    if (obs_infl !== 4'd0) $display("FAIL err_spur_inflight: got %0d want 0", obs_infl); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cnt;
    do_reset();
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (obs_qen !== 1'b0 || obs_outv !== 1'b0)
        $display("FAIL rstmid_quiet[%0d]: got qen=%b outv=%b want 0 0", i, obs_qen, obs_outv);
      else n_pass++;
      if (i == 0) begin
        n_checks++;
        if (obs_infl !== 4'd0) $display("FAIL rstmid_inflight: got %0d want 0", obs_infl); else n_pass++;
      end
    end
    req_valid = '1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_ready != '0) cnt++;
    end
    n_checks++;
    if (cnt != CR) $display("FAIL rstmid_credits: got %0d issues want %0d", cnt, CR); else n_pass++;
    req_valid = '0;
  endtask

`ifdef QSCHED_STRICT_ORDER_EN
  task automatic test_strict_order();
    do_reset();
    req_valid = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs_ready !== 3'b000) $display("FAIL strict_wait[%0d]: got %b want 000", i, obs_ready); else n_pass++;
    end
    req_valid = 3'b011;
    tick();
    n_checks++;
    if (obs_ready !== 3'b001) $display("FAIL strict_g0: got %b want 001", obs_ready); else n_pass++;
    tick();
    n_checks++;
    if (obs_ready !== 3'b010) $display("FAIL strict_g1: got %b want 010", obs_ready); else n_pass++;
    req_valid = '0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      credit_ret = ((CR - m_credits) > 0) && ($urandom_range(2) == 0);
      tick();
      n_checks++;
      if (obs_ready !== exp_ready) $display("FAIL rnd_ready[%0d]: got %b want %b", c, obs_ready, exp_ready); else n_pass++;
      n_checks++;
      if (obs_qen !== exp_qen) $display("FAIL rnd_qen[%0d]: got %b want %b", c, obs_qen, exp_qen); else n_pass++;
      n_checks++;
      if (obs_qz !== exp_qz) $display("FAIL rnd_qz[%0d]: got %h want %h", c, obs_qz, exp_qz); else n_pass++;
      n_checks++;
      if (int'(obs_infl) != exp_infl) $display("FAIL rnd_inflight[%0d]: got %0d want %0d", c, obs_infl, exp_infl); else n_pass++;
      n_checks++;
      if (obs_err !== exp_err) $display("FAIL rnd_err[%0d]: got %b want %b", c, obs_err, exp_err); else n_pass++;
      if (obs_outv && exp_has_src) begin
        n_checks++;
        if (int'(obs_src) != exp_src) $display("FAIL rnd_src[%0d]: got %0d want %0d", c, obs_src, exp_src); else n_pass++;
      end
      // a pending request stays up until granted
      for (int i = 0; i < N; i++)
        if (!(req_valid[i] && g_this != i)) req_valid[i] = 1'($urandom_range(1));
    end
    req_valid = '0; credit_ret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; credit_ret = 1'b0; q_out_enable = 1'b0; spur = 1'b0;
    qpipe = '0; m_credits = CR; m_tags.delete(); m_err = 0; m_qen = 0; m_qz = '0;
`ifdef QSCHED_STRICT_ORDER_EN
    m_ptr = 0;
`else
    m_last = N - 1;
`endif
    for (int i = 0; i < N; i++) req_block[i] = rand_blk();
    test_reset();
    test_single();
    test_back_to_back();
    test_credit_limit();
    test_err();
    test_reset_mid();
`ifdef QSCHED_STRICT_ORDER_EN
    test_strict_order();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/quant_scheduler.md
# quant_scheduler

Issue controller that shares one luma quantizer instance among `NUM_REQ` DCT engines. It sits between the DCT engines and the quantizer, where it does four things: arbitrates 8x8 coefficient blocks, registers the selected block onto the quantizer input together with its enable pulse, tracks the source of every in-flight block, and throttles issue against downstream credits. The quantizer has no back-pressure, so the credit loop is the only thing protecting the entropy-coder input buffer.

## Interface
- `NUM_REQ`, 2: number of requesting DCT engines; legal range 2..4.
- `CREDITS`, 2: downstream block slots; legal range 1..8. This is also the maximum number of blocks in flight.
- `SRC_W`, `$clog2(NUM_REQ)`: width of the source index.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset. The same `rst` drives the shared quantizer.
- `req_valid` in [NUM_REQ]: engine i holds a block.
- `req_ready` out [NUM_REQ]: one-hot grant; a handshake completes when `req_valid[i] && req_ready[i]` at an edge.
- `req_block` in [NUM_REQ][8][8] x 11: coefficient blocks; must stay stable while valid.
- `q_enable` out 1: quantizer enable; a one-cycle pulse per block.
- `q_z` out [8][8] x 11: quantizer `Z` input; valid while `q_enable`=1.
- `q_out_enable` in 1: quantizer output-valid strobe.
- `out_valid` out 1: equals `q_out_enable` (combinational pass-through).
- `out_src` out SRC_W: source index of the block currently on the quantizer output.
- `credit_ret` in 1: downstream freed one slot (one-cycle pulse).
- `in_flight` out 4: blocks issued but not yet output.
- `err` out 1: sticky protocol error flag.

## Operation
- Issue condition: `credits > 0`. When it holds, exactly one valid requester is granted via `req_ready`; when it does not, all `req_ready` are 0.
- Arbitration: round-robin. Search starts at `last_grant+1` (mod NUM_REQ). `last_grant` updates on each handshake; reset value is NUM_REQ-1, so requester 0 wins first.
- On a handshake at edge t:
  - `q_z <= req_block[grant]` and `q_enable <= 1` for exactly one cycle.
  - Source index is pushed into the tag FIFO (depth 8).
  - `credits` decrements.
- Tag FIFO: pop on `q_out_enable`. `out_src` is the FIFO head.
- Credit counter: reset value is `CREDITS`.
  - `credit_ret` increments it.
  - Issue and `credit_ret` in the same cycle leave it unchanged.
  - `credit_ret` at `CREDITS` saturates and sets `err`.
- `in_flight`: +1 on issue, -1 on `q_out_enable`, unchanged when both occur.
- `q_out_enable` with an empty tag FIFO sets `err`; the FIFO is not popped.
- `req_ready` is combinational from `req_valid`, `credits` and `last_grant`. `valid` must not depend on `ready`.
- No state machine beyond the counters; the block is idle whenever `in_flight`=0 and no handshake is occurring.

## Timing
- Reset values: `req_ready`=0 during `rst`; `q_enable`=0, `q_z`=0, `out_src`=0, `in_flight`=0, `err`=0; credits=`CREDITS`; tag FIFO empty.
- Handshake at edge t: `q_enable`=1 during cycle t+1, and the quantizer captures at edge t+1.
- Quantizer latency: `q_out_enable` is high in cycle t+5, which is 4 cycles after the `q_enable` cycle.
- Sustained throughput: one block per cycle while credits are available. Back-to-back issue is legal because the quantizer pipeline stages are gated independently.
- Reset mid-operation clears in-flight tags and credits. The quantizer is reset by the same edge, so no `out_valid` follows reset.

## Configuration
- `QSCHED_STRICT_ORDER_EN` defined: grants are issued strictly in order 0,1,..,NUM_REQ-1,0,...
  - Only the expected requester may be granted; others wait even if valid.
  - The expected index advances on each handshake and resets to 0.
- `QSCHED_STRICT_ORDER_EN` undefined: work-conserving round-robin as described in Operation.

## Test plan
- Single block, CREDITS=2: req 0 valid at cycle 2 → `req_ready[0]`=1 in cycle 2; `q_enable` in cycle 3; `out_valid`=1 with `out_src`=0 in cycle 7; credits=1 until `credit_ret`.
- Both requesters valid continuously, CREDITS=8, `credit_ret` every cycle → grants alternate 0,1,0,1; one `q_enable` per cycle; `out_src` sequence matches the grant sequence 5 cycles later.
- CREDITS=2, no `credit_ret` → exactly 2 issues, then all `req_ready`=0; one `credit_ret` pulse → exactly one further issue.
- `credit_ret` with credits=CREDITS → `err`=1 and sticks; credits stay at CREDITS. Spurious `q_out_enable` with `in_flight`=0 → `err`=1.
- Reset asserted 2 cycles after an issue → `q_enable`/`out_valid` remain 0 afterwards; credits=CREDITS and `in_flight`=0 in the cycle after reset.
- With `QSCHED_STRICT_ORDER_EN`, only req 1 valid → no grant; req 0 then valid → grant 0, then grant 1.
